// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: start/stimulus/result bundle between the sweeper
// (master) and the environment that hosts the function block under sweep
// (slave). The first_fail signal exists only when TTS_FIRST_FAIL_EN is defined.
interface truth_table_sweeper_if;
  logic        start;
  logic        f;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] truth_tbl;
`ifdef TTS_FIRST_FAIL_EN
  logic [4:0]  first_fail;
`endif

  modport master (
    input  start, f,
    output a, b, c, d, busy, done, pass, truth_tbl
`ifdef TTS_FIRST_FAIL_EN
    , output first_fail
`endif
  );

  modport slave (
    output start, f,
    input  a, b, c, d, busy, done, pass, truth_tbl
`ifdef TTS_FIRST_FAIL_EN
    , input first_fail
`endif
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {a,b,c,d} combinations in ascending order,
// holds each for HOLD_CYCLES cycles, samples f on the last edge of each hold and
// compares the captured truth table against EXPECTED.
// Optional feature macro: TTS_FIRST_FAIL_EN (adds first_fail, lowest failing vector).
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | sweeping vectors, busy high
// DONE  | sweep finished, done/pass valid until next start
module truth_table_sweeper #(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  truth_table_sweeper_if.master bus
);

  localparam logic [7:0] HC_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hc_q, hc_d;
  logic [15:0] cap_q, cap_d;
  logic        pass_q, pass_d;
  logic [15:0] cap_upd;
  logic        sample;
  logic        accept;

  // A sample happens on the last edge of each hold; accept is a start taken in IDLE or DONE.
  assign sample = (state_q == RUN) && (hc_q == HC_LAST);
  assign accept = bus.start && (state_q != RUN);

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      hc_q    <= 8'd0;
      cap_q   <= 16'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hc_q    <= hc_d;
      cap_q   <= cap_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and datapath update; pass is computed from the table including the final sample.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hc_d         = hc_q;
    cap_d        = cap_q;
    pass_d       = pass_q;
    cap_upd      = cap_q;
    cap_upd[idx_q] = bus.f;
    if (accept) begin
      state_d = RUN;
      idx_d   = 4'd0;
      hc_d    = 8'd0;
      cap_d   = 16'd0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          hc_d = hc_q + 8'd1;
          if (sample) begin
            cap_d = cap_upd;
            hc_d  = 8'd0;
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_d = DONE;
              pass_d  = (cap_upd == EXPECTED);
            end
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.a         = idx_q[3];
  assign bus.b         = idx_q[2];
  assign bus.c         = idx_q[1];
  assign bus.d         = idx_q[0];
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.truth_tbl = cap_q;

`ifdef TTS_FIRST_FAIL_EN
  logic [4:0] ff_q, ff_d;

  // Latch only the first mismatching vector of a sweep; later mismatches leave it alone.
  always_comb begin
    ff_d = ff_q;
    if (accept)
      ff_d = 5'd0;
    else if (sample && (bus.f != EXPECTED[idx_q]) && !ff_q[4])
      ff_d = {1'b1, idx_q};
  end

  // First-fail register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_q <= 5'd0;
    else     ff_q <= ff_d;
  end

  assign bus.first_fail = ff_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: two sweepers (HOLD 4 / XOR table, HOLD 2 / AND table)
// driven by directed starts; expected results are queued at each start and a
// monitor pops and compares when done rises.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sweeper_if if4 ();
  truth_table_sweeper_if if2 ();

  truth_table_sweeper #(.HOLD_CYCLES(4), .EXPECTED(16'h6996)) dut4 (
    .clk(clk), .rst(rst), .bus(if4)
  );
  truth_table_sweeper #(.HOLD_CYCLES(2), .EXPECTED(16'hF000)) dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  // Function block model: mode 0 = a^b^c^d, mode 1 = a&b; mask bits force f=1.
  int          mode4 = 0;
  int          mode2 = 1;
  logic [15:0] mask4 = 16'h0000;
  logic [15:0] mask2 = 16'h0000;

  function automatic logic model(input int mode, input logic [15:0] mask, input logic [3:0] v);
    logic r;
    r = (mode == 0) ? ^v : (v[3] & v[2]);
    if (mask[v]) r = 1'b1;
    return r;
  endfunction

  assign if4.f = model(mode4, mask4, {if4.a, if4.b, if4.c, if4.d});
  assign if2.f = model(mode2, mask2, {if2.a, if2.b, if2.c, if2.d});

  typedef struct {
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  ff;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  exp_t e4, e2;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [15:0] t, input logic p, input logic [4:0] ff, input int lat);
    exp_t e;
    e.tbl = t; e.pass = p; e.ff = ff; e.lat = lat; e.start_cyc = 0;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic [15:0] tbl, input logic p);
    check({tag, "_table"}, 32'(tbl), 32'(e.tbl));
    check({tag, "_pass"}, 32'(p), 32'(e.pass));
    check({tag, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
  endtask

  // Monitor: on each rising done, pop the oldest expectation and compare.
  logic d4_prev = 1'b0;
  logic d2_prev = 1'b0;
  always @(negedge clk) begin
    if (if4.done && !d4_prev) begin
      check("dut4_done_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        compare("dut4", e4, if4.truth_tbl, if4.pass);
`ifdef TTS_FIRST_FAIL_EN
        check("dut4_first_fail", 32'(if4.first_fail), 32'(e4.ff));
`endif
      end
    end
    d4_prev = if4.done;
    if (if2.done && !d2_prev) begin
      check("dut2_done_expected", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        compare("dut2", e2, if2.truth_tbl, if2.pass);
`ifdef TTS_FIRST_FAIL_EN
        check("dut2_first_fail", 32'(if2.first_fail), 32'(e2.ff));
`endif
      end
    end
    d2_prev = if2.done;
  end

  // One-cycle start; returns at the negedge after the accepting edge.
  task automatic pulse(input int which, input bit push, input exp_t e);
    @(negedge clk);
    e.start_cyc = cyc + 1;
    if (which == 4) begin
      if (push) q4.push_back(e);
      if4.start = 1'b1;
    end else begin
      if (push) q2.push_back(e);
      if2.start = 1'b1;
    end
    @(negedge clk);
    if4.start = 1'b0;
    if2.start = 1'b0;
  endtask

  task automatic wait_drain(input int which, input int budget);
    int n = 0;
    while (((which == 4) ? q4.size() : q2.size()) > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check((which == 4) ? "dut4_drain" : "dut2_drain",
          32'((which == 4) ? q4.size() : q2.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if4.start = 1'b0;
    if2.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vec4", 32'({if4.a, if4.b, if4.c, if4.d}), 32'd0);
    check("rst_busy4", 32'(if4.busy), 32'd0);
    check("rst_done4", 32'(if4.done), 32'd0);
    check("rst_pass4", 32'(if4.pass), 32'd0);
    check("rst_table4", 32'(if4.truth_tbl), 32'd0);
    check("rst_busy2", 32'(if2.busy), 32'd0);
    check("rst_done2", 32'(if2.done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // XOR sweep, HOLD 4; a second start at cycle 10 must be ignored.
    mode4 = 0; mask4 = 16'h0000;
    pulse(4, 1'b1, mk(16'h6996, 1'b1, 5'h00, 64));
    for (int j = 0; j < 64; j++) begin
      if (j > 0) @(negedge clk);
      check($sformatf("dut4_vec_c%0d", j), 32'({if4.a, if4.b, if4.c, if4.d}), 32'(j / 4));
      check($sformatf("dut4_busy_c%0d", j), 32'(if4.busy), 32'd1);
      if4.start = (j == 10);
    end
    @(negedge clk);
    check("dut4_end_busy", 32'(if4.busy), 32'd0);
    check("dut4_end_done", 32'(if4.done), 32'd1);
    check("dut4_end_vec", 32'({if4.a, if4.b, if4.c, if4.d}), 32'd0);
    wait_drain(4, 10);
    repeat (5) @(negedge clk);
    check("dut4_done_sticky", 32'(if4.done), 32'd1);
    check("dut4_pass_sticky", 32'(if4.pass), 32'd1);

    // Reset 30 cycles into a sweep clears everything without a clock.
    pulse(4, 1'b0, mk(16'h0000, 1'b0, 5'h00, 0));
    repeat (29) @(negedge clk);
    check("dut4_pre_rst_busy", 32'(if4.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_vec", 32'({if4.a, if4.b, if4.c, if4.d}), 32'd0);
    check("mid_rst_busy", 32'(if4.busy), 32'd0);
    check("mid_rst_done", 32'(if4.done), 32'd0);
    check("mid_rst_pass", 32'(if4.pass), 32'd0);
    check("mid_rst_table", 32'(if4.truth_tbl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 32'(if4.busy), 32'd0);
    check("post_rst_done", 32'(if4.done), 32'd0);
    check("post_rst_vec", 32'({if4.a, if4.b, if4.c, if4.d}), 32'd0);

    // AND sweep, HOLD 2, f forced high at vector 5.
    mode2 = 1; mask2 = 16'h0020;
    pulse(2, 1'b1, mk(16'hF020, 1'b0, 5'h15, 32));
    wait_drain(2, 50);

    // Restart from DONE with mismatches at vectors 3 and 9.
    mask2 = 16'h0208;
    pulse(2, 1'b1, mk(16'hF208, 1'b0, 5'h13, 32));
    check("dut2_restart_done", 32'(if2.done), 32'd0);
    check("dut2_restart_busy", 32'(if2.busy), 32'd1);
    wait_drain(2, 50);

    // Clean AND sweep restarted from DONE.
    mask2 = 16'h0000;
    pulse(2, 1'b1, mk(16'hF000, 1'b1, 5'h00, 32));
    wait_drain(2, 50);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
